// File: rtl/multi_pulse_gen_pkg.sv
// Shared types and reset defaults for the multi-channel pulse generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: channel state enum, per-channel configuration record and the
// power-on configuration used by both the shadow and active registers.
package multi_pulse_gen_pkg;

   // Configuration fields are held at a fixed width so the record can live in
   // the package; a channel only ever loads its low NBITS bits, the upper bits
   // stay zero.
   localparam int CFG_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RUN   = 2'd2
   } state_t;

   typedef struct packed {
      logic [CFG_W-1:0] period;   // cycle length minus 1
      logic [CFG_W-1:0] width;    // high cycles per period
      logic [CFG_W-1:0] phase;    // delay cycles before the first period
      logic             oneshot;  // 1 = single period per trigger
   } chan_cfg_t;

   localparam logic [CFG_W-1:0] DEF_WIDTH   = CFG_W'(1);
   localparam logic [CFG_W-1:0] DEF_PHASE   = '0;
   localparam logic             DEF_ONESHOT = 1'b0;

   // Power-on config: longest period, one-cycle pulse, no phase, continuous.
   // With en held high this is the legacy free-running single-cycle strobe.
   function automatic chan_cfg_t cfg_default(input int nbits);
      chan_cfg_t c;
      c.period  = (CFG_W'(1) << nbits) - CFG_W'(1);
      c.width   = DEF_WIDTH;
      c.phase   = DEF_PHASE;
      c.oneshot = DEF_ONESHOT;
      return c;
   endfunction

endpackage

// File: rtl/multi_pulse_gen_chan.sv
// One pulse generator channel: FSM, counter, shadow/active config, output flops.
// Latency: pulse/wrap are registered one cycle after the state/count they decode.
// Backpressure: none; en/trig are sampled every cycle and outputs free-run.
//
// Ports: clk, rst (async, active-high); wr + wr_period/wr_width/wr_phase/
// wr_oneshot load the shadow config; en, trig control the channel;
// pulse, wrap (registered) and busy (state != IDLE) are the outputs.
module pulse_chan
   import multi_pulse_gen_pkg::*;
#(
   parameter int NBITS = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [NBITS-1:0] wr_period,
   input  logic [NBITS-1:0] wr_width,
   input  logic [NBITS-1:0] wr_phase,
   input  logic             wr_oneshot,
   input  logic             en,
   input  logic             trig,
   output logic             pulse,
   output logic             wrap,
   output logic             busy
);

   localparam chan_cfg_t CFG_RST = cfg_default(NBITS);

   state_t           state, state_nxt;
   logic [NBITS-1:0] cnt, cnt_nxt;
   logic [CFG_W-1:0] cnt_x;
   logic             pulse_nxt, wrap_nxt;

   chan_cfg_t        shadow, active;
   logic             pending;
   logic             at_end;
   logic             commit;
   logic [CFG_W-1:0] eff_phase;
   logic             eff_oneshot;
   logic             start;

   assign cnt_x  = CFG_W'(cnt);

   // Last cycle of a RUN period. The counter never exceeds period because
   // the active config only changes on this cycle or while idle.
   assign at_end = (state == RUN) && (cnt_x >= active.period);

   // A pending shadow is only adopted between periods or while idle.
   assign commit = pending && ((state == IDLE) || at_end);

   // While idle, a pending shadow is committed on the same edge the channel
   // starts, so the start decision must already look at the shadow values.
   always_comb begin
      eff_phase   = active.phase;
      eff_oneshot = active.oneshot;
      if ((state == IDLE) && pending) begin
         eff_phase   = shadow.phase;
         eff_oneshot = shadow.oneshot;
      end
   end

   assign start = en && (!eff_oneshot || trig);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      wrap_nxt  = 1'b0;
      if (!en) begin
         // Disable wins in every state and silences the outputs on this edge.
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt_nxt   = '0;
                  state_nxt = (eff_phase != '0) ? DELAY : RUN;
               end
            end
            DELAY: begin
               if ((cnt_x + CFG_W'(1)) >= active.phase) begin
                  state_nxt = RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + NBITS'(1);
               end
            end
            RUN: begin
               pulse_nxt = (cnt_x < active.width);
               wrap_nxt  = (cnt_x == active.period);
               if (at_end) begin
                  cnt_nxt = '0;
                  if (active.oneshot) begin
                     state_nxt = IDLE;
                  end
               end else begin
                  cnt_nxt = cnt + NBITS'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         pulse <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         pulse <= pulse_nxt;
         wrap  <= wrap_nxt;
      end
   end

   // A write landing on a commit edge keeps pending set so the newer values
   // are picked up at the next opportunity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= CFG_RST;
         active  <= CFG_RST;
         pending <= 1'b0;
      end else begin
         if (commit) begin
            active <= shadow;
         end
         if (wr) begin
            shadow.period  <= CFG_W'(wr_period);
            shadow.width   <= CFG_W'(wr_width);
            shadow.phase   <= CFG_W'(wr_phase);
            shadow.oneshot <= wr_oneshot;
            pending        <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/multi_pulse_gen.sv
// NCH-channel programmable pulse generator with double-buffered configuration.
// Latency: pulse/wrap registered, one cycle after the channel state/count.
// Backpressure: none; config writes are accepted every cycle, outputs free-run.
//
// Ports: clk, rst (async, active-high); cfg_wr/cfg_ch with cfg_period,
// cfg_width, cfg_phase, cfg_oneshot write one channel's shadow config
// (cfg_ch >= NCH is dropped); en/trig per channel; pulse, wrap, busy per channel.
module multi_pulse_gen
   import multi_pulse_gen_pkg::*;
#(
   parameter int NBITS = 8,
   parameter int NCH   = 2,
   parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [NBITS-1:0] cfg_period,
   input  logic [NBITS-1:0] cfg_width,
   input  logic [NBITS-1:0] cfg_phase,
   input  logic             cfg_oneshot,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   trig,
   output logic [NCH-1:0]   pulse,
   output logic [NCH-1:0]   wrap,
   output logic [NCH-1:0]   busy
);

   logic [NCH-1:0] ch_wr;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      // Out-of-range channel numbers match no instance and are dropped.
      assign ch_wr[g] = cfg_wr && (cfg_ch == CHW'(g));

      pulse_chan #(
         .NBITS (NBITS)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .wr         (ch_wr[g]),
         .wr_period  (cfg_period),
         .wr_width   (cfg_width),
         .wr_phase   (cfg_phase),
         .wr_oneshot (cfg_oneshot),
         .en         (en[g]),
         .trig       (trig[g]),
         .pulse      (pulse[g]),
         .wrap       (wrap[g]),
         .busy       (busy[g])
      );
   end

endmodule
